// File: rtl/mdu_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide step per cycle.
// Optional `MDU_EARLY_OUT_EN: divide-by-zero, DIV overflow and zero MUL operands finish at capture.
module mdu_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_e,
  input  logic [2:0]      i_op,
  input  logic            i_w32,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_valid,
  output logic [XLEN-1:0] o_dest,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]   ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MINV    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LST = CNT_W'(XLEN - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_spec;
  logic [XLEN-1:0]     r_spec_val;

  logic                w_s1_sgn, w_s2_sgn, w_neg1, w_neg2, w_neg_cap;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic                w_div0, w_ovf, w_mulz, w_spec;
  logic [XLEN-1:0]     w_spec_val;
  logic [XLEN:0]       w_msum, w_rsh, w_rdiff;
  logic [2*XLEN-1:0]   w_mstep, w_dstep, w_step, w_prod;
  logic [XLEN-1:0]     w_dval, w_dres, w_res;
  logic                w_unused;

  assign w_unused = i_w32;

  // Operand signedness per funct3
  always_comb begin
    w_s1_sgn = 1'b0;
    w_s2_sgn = 1'b0;
    case (i_op)
      3'd1, 3'd4, 3'd6: begin
        w_s1_sgn = 1'b1;
        w_s2_sgn = 1'b1;
      end
      3'd2:    w_s1_sgn = 1'b1;
      default: begin
        w_s1_sgn = 1'b0;
        w_s2_sgn = 1'b0;
      end
    endcase
  end

  assign w_neg1    = w_s1_sgn & i_src1[XLEN-1];
  assign w_neg2    = w_s2_sgn & i_src2[XLEN-1];
  assign w_mag1    = w_neg1 ? -i_src1 : i_src1;
  assign w_mag2    = w_neg2 ? -i_src2 : i_src2;
  // Remainder follows the dividend sign; products and quotients follow the sign product
  assign w_neg_cap = (i_op[2] & i_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div0 = i_op[2] & (i_src2 == ZERO);
  assign w_ovf  = i_op[2] & ~i_op[0] & (i_src1 == MINV) & (i_src2 == ONES);
  assign w_mulz = ~i_op[2] & ((i_src1 == ZERO) | (i_src2 == ZERO));
  assign w_spec = w_div0 | w_ovf;

  // Forced results for divide-by-zero and signed overflow
  always_comb begin
    if (w_div0) begin
      w_spec_val = i_op[1] ? i_src1 : ONES;
    end else if (w_ovf) begin
      w_spec_val = i_op[1] ? ZERO : MINV;
    end else begin
      w_spec_val = ZERO;
    end
  end

  // r_acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign w_msum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mstep = {w_msum, r_acc[XLEN-1:1]};
  assign w_rsh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_rdiff = w_rsh - {1'b0, r_opnd};
  assign w_dstep = w_rdiff[XLEN] ? {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                 : {w_rdiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_step  = r_op[2] ? w_dstep : w_mstep;

  assign w_prod = r_neg ? -w_step : w_step;
  assign w_dval = r_op[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
  assign w_dres = r_neg ? -w_dval : w_dval;

  // Final result selection from the last step
  always_comb begin
    if (r_spec) begin
      w_res = r_spec_val;
    end else if (r_op[2]) begin
      w_res = w_dres;
    end else if (r_op[1:0] == 2'd0) begin
      w_res = w_prod[XLEN-1:0];
    end else begin
      w_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_op       <= 3'd0;
      r_opnd     <= ZERO;
      r_acc      <= {(2*XLEN){1'b0}};
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= ZERO;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      if (!i_rst_n) begin
        o_dest <= ZERO;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_e) begin
            r_op       <= i_op;
            r_opnd     <= i_op[2] ? w_mag2 : w_mag1;
            r_acc      <= {ZERO, (i_op[2] ? w_mag1 : w_mag2)};
            r_neg      <= w_neg_cap;
            r_spec     <= w_spec;
            r_spec_val <= w_spec_val;
            r_cnt      <= {CNT_W{1'b0}};
            o_busy     <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
            if (w_spec || w_mulz) begin
              o_dest  <= w_spec_val;
              o_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LST) begin
            o_dest  <= w_res;
            o_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          if (!i_stall) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed + random bench for mdu_seq_ctrl; expected results are queued at issue, compared at o_valid.
module tb_mdu_seq_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_stall;
  logic        i_e;
  logic [2:0]  i_op;
  logic        i_w32;
  logic [31:0] i_src1;
  logic [31:0] i_src2;
  logic        o_valid;
  logic [31:0] o_dest;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  mdu_seq_ctrl #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_stall(i_stall),
    .i_e(i_e), .i_op(i_op), .i_w32(i_w32), .i_src1(i_src1), .i_src2(i_src2),
    .o_valid(o_valid), .o_dest(o_dest), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_for(input bit early);
`ifdef MDU_EARLY_OUT_EN
    return early ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 32'd0) || (b == 32'd0);
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input bit now);
    int lat;
    logic [31:0] held;
    if (!now) begin @(posedge i_clk); #1; end
    i_op = op; i_src1 = a; i_src2 = b; i_e = 1'b1; i_stall = (hold > 0);
    sb.push_back(exp);
    lat = 0;
    do begin
      @(posedge i_clk); #1;
      i_e = 1'b0;
      lat++;
      if (lat == 1) chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
    end while (!o_valid && lat < 100);
    chk({tag, " lat"}, 32'(lat), 32'(lat_for(is_early(op, a, b))));
    chk(tag, o_dest, sb.pop_front());
    if (hold > 0) begin
      held = o_dest;
      repeat (hold) begin
        @(posedge i_clk); #1;
        chk({tag, " hold valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, " hold dest"}, o_dest, held);
      end
      i_stall = 1'b0;
      @(posedge i_clk); #1;
      chk({tag, " release"}, {31'd0, o_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    i_rst_n = 1'b0; i_flush = 1'b0; i_stall = 1'b0; i_e = 1'b0;
    i_op = 3'd0; i_w32 = 1'b0; i_src1 = 32'd0; i_src2 = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst valid", {31'd0, o_valid}, 32'd0);
    chk("rst busy", {31'd0, o_busy}, 32'd0);
    chk("rst dest", o_dest, 32'd0);
    i_rst_n = 1'b1;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1'b0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 1'b0);
    run_op("divu0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("remu0", 3'd7, 32'd100, 32'd0, 32'd100, 0, 1'b0);
    run_op("div0s", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem0s", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 1'b0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_op("div-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("rem-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulz", 3'd1, 32'd0, 32'h1234_5678, 32'd0, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op("rand", rop, ra, rb, ref_mdu(rop, ra, rb), 0, 1'b0);
    end

    run_op("stall", 3'd5, 32'd1000, 32'd7, 32'd142, 5, 1'b0);

    // Abort a DIV at cnt=10, then issue REMU in the first idle cycle
    @(posedge i_clk); #1;
    i_op = 3'd4; i_src1 = 32'd1000; i_src2 = 32'd3; i_e = 1'b1;
    repeat (11) begin @(posedge i_clk); #1; i_e = 1'b0; end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush valid", {31'd0, o_valid}, 32'd0);
    chk("flush busy", {31'd0, o_busy}, 32'd0);
    run_op("remu after flush", 3'd7, 32'd17, 32'd5, 32'd2, 0, 1'b1);

    // Flush while holding a result in DONE
    @(posedge i_clk); #1;
    i_op = 3'd0; i_src1 = 32'd9; i_src2 = 32'd9; i_e = 1'b1; i_stall = 1'b1;
    for (int c = 0; c < 100 && !(c > 0 && o_valid); c++) begin
      @(posedge i_clk); #1; i_e = 1'b0;
    end
    chk("pre-flush valid", {31'd0, o_valid}, 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_stall = 1'b0;
    chk("done flush valid", {31'd0, o_valid}, 32'd0);
    chk("done flush busy", {31'd0, o_busy}, 32'd0);

    // Reset mid-operation clears outputs, including the last result
    @(posedge i_clk); #1;
    i_op = 3'd0; i_src1 = 32'd3; i_src2 = 32'd5; i_e = 1'b1;
    repeat (5) begin @(posedge i_clk); #1; i_e = 1'b0; end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("midrst valid", {31'd0, o_valid}, 32'd0);
    chk("midrst busy", {31'd0, o_busy}, 32'd0);
    chk("midrst dest", o_dest, 32'd0);
    run_op("after rst", 3'd0, 32'd3, 32'd5, 32'd15, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
